// File: rtl/flit_sink.sv
// Receive-side flit endpoint: HEAD/DATA/TAIL framing check plus packet, flit, error and toggle statistics.
// Build with FLIT_SINK_TOGGLE_EN defined to include the payload toggle-counting path.
module flit_sink #(
  parameter int DATAW  = 66,
  parameter int TYPEW  = 2,
  parameter int VCHW   = 1,
  parameter int CNTW   = 32,
  parameter int MAXLEN = 64
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  input  logic             clr,
  output logic             busy,
  output logic             pkt_done,
  output logic [15:0]      pkt_len,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  flit_cnt,
  output logic [CNTW-1:0]  err_cnt,
  output logic             err,
  output logic [7:0]       toggle_last,
  output logic [CNTW-1:0]  toggle_cnt
);

  localparam int PW = DATAW - TYPEW;
  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(2);
  localparam logic [TYPEW-1:0] T_DATA = TYPEW'(3);

  typedef enum logic [0:0] {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [VCHW-1:0]  cur_vch_q, cur_vch_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      pkt_len_q, pkt_len_d;
  logic [CNTW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNTW-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNTW-1:0]  err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             pkt_done_q, pkt_done_d;
  logic             frame_err_s;
  logic [TYPEW-1:0] flit_type_s;
  logic             flit_ok_s;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNTW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign flit_type_s = idata[DATAW-1 -: TYPEW];
  assign flit_ok_s   = ivalid && (flit_type_s != T_NONE);

  // Framing FSM and packet/flit/error counters: next-state logic.
  always_comb begin
    state_d     = state_q;
    cur_vch_d   = cur_vch_q;
    len_d       = len_q;
    pkt_len_d   = pkt_len_q;
    pkt_cnt_d   = pkt_cnt_q;
    flit_cnt_d  = flit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    pkt_done_d  = 1'b0;
    frame_err_s = 1'b0;
    if (clr) begin
      state_d    = IDLE;
      cur_vch_d  = {VCHW{1'b0}};
      len_d      = 16'd0;
      pkt_len_d  = 16'd0;
      pkt_cnt_d  = {CNTW{1'b0}};
      flit_cnt_d = {CNTW{1'b0}};
      err_cnt_d  = {CNTW{1'b0}};
      err_d      = 1'b0;
    end else if (flit_ok_s) begin
      flit_cnt_d = sat_inc(flit_cnt_q);
      case (state_q)
        IDLE: begin
          if (flit_type_s == T_HEAD) begin
            state_d   = BODY;
            cur_vch_d = ivch;
            len_d     = 16'd0;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        BODY: begin
          // A channel switch mid-packet aborts regardless of flit type.
          if (ivch != cur_vch_q) begin
            frame_err_s = 1'b1;
            state_d     = IDLE;
          end else begin
            case (flit_type_s)
              T_DATA: begin
                if (len_q >= 16'(MAXLEN)) begin
                  frame_err_s = 1'b1;
                  state_d     = IDLE;
                end else begin
                  len_d = len_q + 16'd1;
                end
              end
              T_TAIL: begin
                pkt_len_d  = len_q;
                pkt_cnt_d  = sat_inc(pkt_cnt_q);
                pkt_done_d = 1'b1;
                state_d    = IDLE;
              end
              T_HEAD: begin
                frame_err_s = 1'b1;
                cur_vch_d   = ivch;
                len_d       = 16'd0;
              end
              default: frame_err_s = 1'b0;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
      if (frame_err_s) begin
        err_cnt_d = sat_inc(err_cnt_q);
        err_d     = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      pkt_done_d = 1'b0;
    end
  end

  // Framing FSM and counter registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      cur_vch_q  <= {VCHW{1'b0}};
      len_q      <= 16'd0;
      pkt_len_q  <= 16'd0;
      pkt_cnt_q  <= {CNTW{1'b0}};
      flit_cnt_q <= {CNTW{1'b0}};
      err_cnt_q  <= {CNTW{1'b0}};
      err_q      <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_vch_q  <= cur_vch_d;
      len_q      <= len_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign busy     = (state_q == BODY);
  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err      = err_q;

`ifdef FLIT_SINK_TOGGLE_EN
  logic [PW-1:0]   prev_q, prev_d;
  logic [PW-1:0]   diff_q, diff_d;
  logic            dv_q, dv_d;
  logic [7:0]      tlast_q, tlast_d;
  logic [CNTW-1:0] tcnt_q, tcnt_d;
  logic [7:0]      pc_s;

  function automatic logic [7:0] popcount(input logic [PW-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < PW; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [7:0] b);
    logic [CNTW:0] s;
    s = {1'b0, a} + (CNTW+1)'(b);
    if (s[CNTW]) begin
      return {CNTW{1'b1}};
    end else begin
      return s[CNTW-1:0];
    end
  endfunction

  assign pc_s = popcount(diff_q);

  // Two-stage toggle pipeline: XOR against previous payload, then popcount and accumulate.
  always_comb begin
    prev_d  = prev_q;
    diff_d  = diff_q;
    dv_d    = 1'b0;
    tlast_d = tlast_q;
    tcnt_d  = tcnt_q;
    if (clr) begin
      prev_d  = {PW{1'b0}};
      diff_d  = {PW{1'b0}};
      tlast_d = 8'd0;
      tcnt_d  = {CNTW{1'b0}};
    end else begin
      if (flit_ok_s) begin
        diff_d = idata[PW-1:0] ^ prev_q;
        prev_d = idata[PW-1:0];
        dv_d   = 1'b1;
      end else begin
        dv_d = 1'b0;
      end
      if (dv_q) begin
        tlast_d = pc_s;
        tcnt_d  = sat_add(tcnt_q, pc_s);
      end else begin
        tlast_d = tlast_q;
      end
    end
  end

  // Toggle pipeline registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev_q  <= {PW{1'b0}};
      diff_q  <= {PW{1'b0}};
      dv_q    <= 1'b0;
      tlast_q <= 8'd0;
      tcnt_q  <= {CNTW{1'b0}};
    end else begin
      prev_q  <= prev_d;
      diff_q  <= diff_d;
      dv_q    <= dv_d;
      tlast_q <= tlast_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign toggle_last = tlast_q;
  assign toggle_cnt  = tcnt_q;
`else
  logic unused_payload_s;
  assign unused_payload_s = ^idata[PW-1:0];
  assign toggle_last = 8'd0;
  assign toggle_cnt  = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_flit_sink.sv
// Directed self-checking bench for flit_sink; toggle expectations follow FLIT_SINK_TOGGLE_EN.
module tb_flit_sink;

  localparam logic [1:0] NONE = 2'd0, HEAD = 2'd1, TAIL = 2'd2, DATA = 2'd3;
`ifdef FLIT_SINK_TOGGLE_EN
  localparam logic [63:0] T23 = 64'd23;
  localparam logic [63:0] T46 = 64'd46;
`else
  localparam logic [63:0] T23 = 64'd0;
  localparam logic [63:0] T46 = 64'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic [65:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic        clr;
  logic        busy, pkt_done, err;
  logic [15:0] pkt_len;
  logic [31:0] pkt_cnt, flit_cnt, err_cnt, toggle_cnt;
  logic [7:0]  toggle_last;
  logic        s_busy, s_pkt_done, s_err;
  logic [15:0] s_pkt_len;
  logic [3:0]  s_pkt_cnt, s_flit_cnt, s_err_cnt, s_toggle_cnt;
  logic [7:0]  s_toggle_last;

  int n_cmp = 0;
  int n_mis = 0;
  int done_seen;

  always #5 clk = ~clk;

  flit_sink dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt),
    .flit_cnt(flit_cnt), .err_cnt(err_cnt), .err(err),
    .toggle_last(toggle_last), .toggle_cnt(toggle_cnt)
  );

  // Narrow-counter instance to observe saturation.
  flit_sink #(.CNTW(4)) dut_s (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(s_busy), .pkt_done(s_pkt_done), .pkt_len(s_pkt_len), .pkt_cnt(s_pkt_cnt),
    .flit_cnt(s_flit_cnt), .err_cnt(s_err_cnt), .err(s_err),
    .toggle_last(s_toggle_last), .toggle_cnt(s_toggle_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, return at next negedge with outputs settled.
  task automatic cyc(input logic v, input logic [1:0] t, input logic vc, input logic [63:0] p);
    ivalid = v;
    idata  = {t, p};
    ivch   = vc;
    @(negedge clk);
    if (pkt_done) done_seen++;
  endtask

  task automatic idle();
    cyc(1'b0, NONE, 1'b0, 64'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    idle();
    clr = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; clr = 1'b0; ivalid = 1'b0; idata = 66'd0; ivch = 1'b0;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    idle();
    chk("rst_busy", busy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_flit_cnt", flit_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_toggle_cnt", toggle_cnt, 0);

    // 10 packets of HEAD + 20 DATA + TAIL, with a valid NONE flit in each gap
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, HEAD, 1'b0, 64'd0);
      if (k == 0) chk("t1_busy", busy, 1);
      for (int d = 0; d < 20; d++) cyc(1'b1, DATA, 1'b0, 64'd0);
      cyc(1'b1, TAIL, 1'b0, 64'd0);
      cyc(1'b1, NONE, 1'b0, 64'd0);
      repeat (6) idle();
    end
    chk("t1_pkt_cnt", pkt_cnt, 10);
    chk("t1_flit_cnt", flit_cnt, 220);
    chk("t1_pkt_len", pkt_len, 20);
    chk("t1_err", err, 0);
    chk("t1_done_pulses", done_seen, 10);
    chk("t1_sat_flit_cnt", s_flit_cnt, 15);
    chk("t1_sat_pkt_cnt", s_pkt_cnt, 10);

    do_clr();
    chk("clr_pkt_cnt", pkt_cnt, 0);
    chk("clr_flit_cnt", flit_cnt, 0);
    chk("clr_pkt_len", pkt_len, 0);

    // DATA in IDLE, then HEAD, HEAD, TAIL
    cyc(1'b1, DATA, 1'b0, 64'd0);
    chk("t2_err_a", err, 1);
    chk("t2_busy_a", busy, 0);
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    chk("t2_busy_b", busy, 1);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    chk("t2_done", pkt_done, 1);
    idle();
    chk("t2_err_cnt", err_cnt, 2);
    chk("t2_err", err, 1);
    chk("t2_pkt_cnt", pkt_cnt, 1);
    chk("t2_pkt_len", pkt_len, 0);
    chk("t2_done_low", pkt_done, 0);

    // VCH change mid-packet
    do_clr();
    chk("clr_err", err, 0);
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b1, 64'd0);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_busy", busy, 0);

    // Exactly MAXLEN DATA flits is a good packet
    do_clr();
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    for (int d = 0; d < 64; d++) cyc(1'b1, DATA, 1'b0, 64'd0);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    chk("t4_max_len", pkt_len, 64);
    chk("t4_max_err", err_cnt, 0);

    // MAXLEN+1 DATA flits overflows
    do_clr();
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    for (int d = 0; d < 64; d++) cyc(1'b1, DATA, 1'b0, 64'd0);
    chk("t4_busy_64", busy, 1);
    chk("t4_err_64", err_cnt, 0);
    cyc(1'b1, DATA, 1'b0, 64'd0);
    chk("t4_err_65", err_cnt, 1);
    chk("t4_busy_65", busy, 0);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    chk("t4_err_tail", err_cnt, 2);
    chk("t4_pkt_cnt", pkt_cnt, 0);

    // Toggle pipeline: payloads 0, 7FFFFF, 7FFFFF, 0
    do_clr();
    idle();
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'h7FFFFF);
    chk("t5_tl0", toggle_last, 0);
    cyc(1'b1, DATA, 1'b0, 64'h7FFFFF);
    chk("t5_tl1", toggle_last, T23);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    chk("t5_tl2", toggle_last, 0);
    chk("t5_tc2", toggle_cnt, T23);
    idle();
    chk("t5_tl3", toggle_last, T23);
    chk("t5_tc3", toggle_cnt, T46);

    // Asynchronous reset mid-packet
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'hF);
    cyc(1'b1, DATA, 1'b0, 64'd0);
    ivalid = 1'b0;
    rst_ = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flit", flit_cnt, 0);
    chk("t6_rst_tc", toggle_cnt, 0);
    chk("t6_rst_pkt", pkt_cnt, 0);
    @(negedge clk);
    rst_ = 1'b1;
    idle();
    chk("t6_rst_err", err_cnt, 0);
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'd0);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    chk("t6_post_rst_pkt", pkt_cnt, 1);
    chk("t6_post_rst_len", pkt_len, 1);
    chk("t6_post_rst_flit", flit_cnt, 3);

    // clr in the same cycle as TAIL drops the flit and the toggle pipeline
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'hFF);
    clr = 1'b1;
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    clr = 1'b0;
    chk("t6_clr_pkt", pkt_cnt, 0);
    chk("t6_clr_done", pkt_done, 0);
    chk("t6_clr_flit", flit_cnt, 0);
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_tl", toggle_last, 0);
    idle();
    chk("t6_clr_tc", toggle_cnt, 0);
    cyc(1'b1, HEAD, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'd0);
    cyc(1'b1, DATA, 1'b0, 64'd0);
    cyc(1'b1, TAIL, 1'b0, 64'd0);
    idle();
    idle();
    chk("t6_new_pkt", pkt_cnt, 1);
    chk("t6_new_len", pkt_len, 2);
    chk("t6_new_flit", flit_cnt, 4);
    chk("t6_new_err", err, 0);
    chk("t6_new_tc", toggle_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
